// File: rtl/cpu_ram_dp_if.sv
// -----------------------------------------------------------------------------
// cpu_ram_dp_if
// Host (bridge/debug) access bundle for the cpu_ram_dp work RAM.
//
// Signals:
//   host_addr   host word address
//   host_req    access request, level; held until host_ack is seen
//   host_we     1 = write, 0 = read; sampled together with host_req
//   host_wdata  write data
//   host_ack    one-cycle access-complete pulse from the RAM
//   host_rdata  read data, valid with host_ack, held until the next read
//
// Modports:
//   master  the host side (drives the request)
//   slave   the RAM side (returns ack and read data)
// -----------------------------------------------------------------------------
interface cpu_ram_dp_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0] host_addr;
    logic              host_req;
    logic              host_we;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;

    modport master (
        output host_addr,
        output host_req,
        output host_we,
        output host_wdata,
        input  host_ack,
        input  host_rdata
    );

    modport slave (
        input  host_addr,
        input  host_req,
        input  host_we,
        input  host_wdata,
        output host_ack,
        output host_rdata
    );
endinterface

// File: rtl/cpu_ram_dp.sv
// -----------------------------------------------------------------------------
// cpu_ram_dp
// Dual-port work RAM for the main CPU.
//   Port A: CPU port, registered read (latency 1) and synchronous write.
//   Port B: shared by a hardware clear sequencer (writes INIT_VAL to every
//           word, one word per cycle) and a host port with a req/ack
//           handshake.
//
// Parameters:
//   DATA_W          data width
//   ADDR_W          address width, DEPTH = 2**ADDR_W words
//   INIT_VAL        word written by the clear sequencer
//   CLEAR_ON_RESET  1 = a full clear starts automatically after reset release
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset (memory contents untouched)
//   cpu_addr   CPU address
//   cpu_wr     CPU write strobe (ignored while clearing)
//   cpu_data   CPU write data
//   cpu_q      CPU registered read data
//   host       cpu_ram_dp_if.slave host access bundle
//   clear_req  single-cycle pulse requesting a full clear (ignored while clearing)
//   busy       high while the clear sequencer runs
//
// Build option:
//   CPU_RAM_WRITE_FIRST_EN  when defined the CPU port is write-first (cpu_q
//                           shows cpu_data in an accepted write cycle);
//                           otherwise read-first. The host port is always
//                           read-first.
// -----------------------------------------------------------------------------
module cpu_ram_dp #(
    parameter int              DATA_W         = 8,
    parameter int              ADDR_W         = 11,
    parameter logic [DATA_W-1:0] INIT_VAL     = {DATA_W{1'b0}},
    parameter bit              CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_wr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic [DATA_W-1:0] cpu_q,
    cpu_ram_dp_if.slave       host,
    input  logic              clear_req,
    output logic              busy
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] CNT_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    logic [DATA_W-1:0] mem_r [DEPTH];

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_nxt_s;
    logic              clr_we_s;
    logic              cpu_we_s;
    logic              host_accept_s;
    logic              host_wr_s;
    logic              collide_s;

    logic [DATA_W-1:0] cpu_q_r;
    logic              host_ack_r;
    logic [DATA_W-1:0] host_rdata_r;
    logic              busy_r;

    // State and clear-address register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if (CLEAR_ON_RESET) begin
                state_r <= ST_CLEAR;
            end else begin
                state_r <= ST_IDLE;
            end
            cnt_r <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic: IDLE starts a clear on clear_req, CLEAR walks every word once
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        clr_we_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clear_req) begin
                    state_nxt_s = ST_CLEAR;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                clr_we_s = 1'b1;
                // The last word returns the counter to zero and leaves CLEAR on the same edge
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Access qualification: CPU writes only in IDLE; a clear request beats a
    // host request, and a host request is not re-accepted in its own ack cycle.
    // A host write colliding with a CPU write to the same word is dropped.
    always_comb begin
        cpu_we_s      = 1'b0;
        host_accept_s = 1'b0;
        collide_s     = 1'b0;
        host_wr_s     = 1'b0;
        if (state_r == ST_IDLE) begin
            cpu_we_s      = cpu_wr;
            host_accept_s = host.host_req & ~host_ack_r & ~clear_req;
            collide_s     = cpu_wr & (cpu_addr == host.host_addr);
            host_wr_s     = host_accept_s & host.host_we & ~collide_s;
        end else begin
            cpu_we_s      = 1'b0;
            host_accept_s = 1'b0;
        end
    end

    // Memory array: port A (CPU) and port B (clear sequencer or host)
    always_ff @(posedge clk) begin
        if (cpu_we_s) begin
            mem_r[cpu_addr] <= cpu_data;
        end
        if (clr_we_s) begin
            mem_r[cnt_r] <= INIT_VAL;
        end else if (host_wr_s) begin
            mem_r[host.host_addr] <= host.host_wdata;
        end
    end

    // CPU read register: reads every cycle, including during a clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_q_r <= {DATA_W{1'b0}};
        end else begin
`ifdef CPU_RAM_WRITE_FIRST_EN
            if (cpu_we_s) begin
                cpu_q_r <= cpu_data;
            end else begin
                cpu_q_r <= mem_r[cpu_addr];
            end
`else
            cpu_q_r <= mem_r[cpu_addr];
`endif
        end
    end

    // Host response: ack one cycle after acceptance, read data held until the next read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            host_ack_r   <= 1'b0;
            host_rdata_r <= {DATA_W{1'b0}};
        end else begin
            host_ack_r <= host_accept_s;
            if (host_accept_s && !host.host_we) begin
                host_rdata_r <= mem_r[host.host_addr];
            end
        end
    end

    // Busy flag registered from the next state so it tracks CLEAR without a lag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r <= CLEAR_ON_RESET;
        end else begin
            busy_r <= (state_nxt_s == ST_CLEAR);
        end
    end

    assign cpu_q           = cpu_q_r;
    assign busy            = busy_r;
    assign host.host_ack   = host_ack_r;
    assign host.host_rdata = host_rdata_r;

endmodule

// File: tb/tb_cpu_ram_dp.sv
// -----------------------------------------------------------------------------
// tb_cpu_ram_dp
// Scoreboard bench for cpu_ram_dp. A reference model updated on each rising
// edge pushes the expected cpu_q/busy for every cycle and the expected host
// response for every accepted host access; a monitor on the falling edge pops
// and compares. Honours CPU_RAM_WRITE_FIRST_EN in the model.
// -----------------------------------------------------------------------------
module tb_cpu_ram_dp;

    localparam int          DATA_W   = 8;
    localparam int          ADDR_W   = 11;
    localparam int          DEPTH    = 2048;
    localparam logic [7:0]  INIT_VAL = 8'hFF;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_wr;
    logic [DATA_W-1:0] cpu_data;
    logic [DATA_W-1:0] cpu_q;
    logic              clear_req;
    logic              busy;

    cpu_ram_dp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) hif ();

    cpu_ram_dp #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .INIT_VAL(INIT_VAL),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cpu_addr(cpu_addr),
        .cpu_wr(cpu_wr),
        .cpu_data(cpu_data),
        .cpu_q(cpu_q),
        .host(hif),
        .clear_req(clear_req),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { bit known; logic [7:0] cpu; bit busy; } cyc_exp_t;
    typedef struct { int cyc; bit rd; bit known; logic [7:0] data; } host_exp_t;

    cyc_exp_t  cq[$];
    host_exp_t hq[$];

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: memory image, clear progress, previous-cycle ack
    logic [7:0] m_mem [DEPTH];
    bit         m_known [DEPTH];
    bit         m_clearing = 1'b1;
    int         m_pos = 0;
    bit         m_ack_prev = 1'b0;
    int         m_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_cyc);
        end
    endtask

    // Model: asynchronous reset drops any pending host response
    initial begin
        forever begin
            @(negedge reset_n);
            if (clk == 1'b0) begin
                hq.delete();
                m_clearing = 1'b1;
                m_pos      = 0;
                m_ack_prev = 1'b0;
            end
        end
    end

    // Model: one step per rising edge
    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        forever begin
            cyc_exp_t  ce;
            host_exp_t he;
            bit idle, cw, acc;
            int ca, ha;
            @(posedge clk);
            m_cyc++;
            if (!reset_n) begin
                hq.delete();
                m_clearing = 1'b1;
                m_pos      = 0;
                m_ack_prev = 1'b0;
                ce.known = 1'b1; ce.cpu = 8'h00; ce.busy = 1'b1;
                cq.push_back(ce);
            end else begin
                ca   = int'(cpu_addr);
                ha   = int'(hif.host_addr);
                idle = !m_clearing;
                ce.known = m_known[ca];
                ce.cpu   = m_mem[ca];
                cw = cpu_wr && idle;
`ifdef CPU_RAM_WRITE_FIRST_EN
                if (cw) begin ce.known = 1'b1; ce.cpu = cpu_data; end
`endif
                acc = idle && hif.host_req && !m_ack_prev && !clear_req;
                if (acc) begin
                    he.cyc = m_cyc; he.rd = !hif.host_we;
                    he.known = m_known[ha]; he.data = m_mem[ha];
                    hq.push_back(he);
                end
                if (m_clearing) begin
                    m_mem[m_pos] = INIT_VAL; m_known[m_pos] = 1'b1;
                    if (m_pos == DEPTH - 1) begin m_clearing = 1'b0; m_pos = 0; end
                    else m_pos++;
                end else begin
                    if (cw) begin m_mem[ca] = cpu_data; m_known[ca] = 1'b1; end
                    if (acc && hif.host_we && !(cw && ca == ha)) begin
                        m_mem[ha] = hif.host_wdata; m_known[ha] = 1'b1;
                    end
                    if (clear_req) begin m_clearing = 1'b1; m_pos = 0; end
                end
                m_ack_prev = acc;
                ce.busy = m_clearing;
                cq.push_back(ce);
            end
        end
    end

    // Monitor: compare on the falling edge
    initial begin
        forever begin
            cyc_exp_t  ce;
            host_exp_t he;
            @(negedge clk);
            if (cq.size() == 0) begin
                chk("cycle_expectation_present", 32'd0, 32'd1);
            end else begin
                ce = cq.pop_front();
                chk("busy", 32'(busy), 32'(ce.busy));
                if (ce.known) chk("cpu_q", 32'(cpu_q), 32'(ce.cpu));
            end
            if (hif.host_ack === 1'b1) begin
                if (hq.size() == 0) begin
                    chk("host_ack_expected", 32'd1, 32'd0);
                end else begin
                    he = hq.pop_front();
                    chk("host_ack_cycle", 32'(m_cyc), 32'(he.cyc));
                    if (he.rd && he.known) chk("host_rdata", 32'(hif.host_rdata), 32'(he.data));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ADDR_W-1:0] pick_addr();
        if ($urandom_range(3) == 0) return ADDR_W'($urandom_range(15));
        return ADDR_W'($urandom);
    endfunction

    task automatic idle_inputs();
        cpu_wr = 1'b0; clear_req = 1'b0; hif.host_req = 1'b0;
    endtask

    task automatic rand_cpu();
        cpu_wr   = 1'($urandom_range(1));
        cpu_addr = pick_addr();
        cpu_data = 8'($urandom);
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            rand_cpu();
            hif.host_req   = ($urandom_range(2) != 0);
            hif.host_we    = 1'($urandom_range(1));
            hif.host_addr  = pick_addr();
            hif.host_wdata = 8'($urandom);
        end
        step();
        idle_inputs();
    endtask

    // Count falling edges with busy high after reset release or clear start
    task automatic measure_busy(input string name);
        int  c = 0;
        bit  done = 1'b0;
        while (!done && c < 5000) begin
            @(negedge clk);
            if (busy) c++;
            else done = 1'b1;
        end
        chk(name, 32'(c), 32'd2048);
        step();
    endtask

    task automatic host_op(input bit we, input logic [ADDR_W-1:0] a, input logic [7:0] d);
        int w = 0;
        hif.host_we = we; hif.host_addr = a; hif.host_wdata = d; hif.host_req = 1'b1;
        do begin step(); w++; end while (!hif.host_ack && w < 5000);
        hif.host_req = 1'b0;
        chk("host_op_timeout", 32'(w >= 5000), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_cpu_q", 32'(cpu_q), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_host_ack", 32'(hif.host_ack), 32'd0);
        chk("rst_host_rdata", 32'(hif.host_rdata), 32'd0);
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        int w;
        cpu_addr = '0; cpu_data = '0; cpu_wr = 1'b0; clear_req = 1'b0;
        hif.host_req = 1'b0; hif.host_we = 1'b0; hif.host_addr = '0; hif.host_wdata = '0;

        // reset and automatic clear
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        measure_busy("busy_after_reset");

        // CPU write then read, plus boundary reads
        cpu_wr = 1'b1; cpu_addr = 11'h010; cpu_data = 8'h3C;
        step(); cpu_wr = 1'b0;
        step(); cpu_addr = 11'h000;
        step(); cpu_addr = 11'h3FF;
        step(); cpu_addr = 11'h7FF;
        step();

        // host write, then held host read
        host_op(1'b1, 11'h400, 8'h7E);
        hif.host_we = 1'b0; hif.host_addr = 11'h400; hif.host_req = 1'b1;
        repeat (6) step();
        hif.host_req = 1'b0;
        step();

        // same-cycle CPU and host write to one word
        cpu_wr = 1'b1; cpu_addr = 11'h005; cpu_data = 8'h11;
        hif.host_we = 1'b1; hif.host_addr = 11'h005; hif.host_wdata = 8'h22; hif.host_req = 1'b1;
        step();
        cpu_wr = 1'b0; hif.host_req = 1'b0;
        step();
        host_op(1'b0, 11'h005, 8'h00);
        step();

        rand_cycles(600);

        // clear request with simultaneous host request
        step();
        clear_req = 1'b1;
        hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_addr = pick_addr();
        w = 0;
        do begin
            step(); w++;
            clear_req = 1'b0;
            rand_cpu();
        end while (!hif.host_ack && w < 3000);
        hif.host_req = 1'b0; cpu_wr = 1'b0;
        chk("clear_ack_delay", 32'(w), 32'd2050);
        for (int i = 0; i < 8; i++) host_op(1'b0, pick_addr(), 8'h00);
        rand_cycles(300);

        // reset in the middle of a clear
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 500; i++) begin rand_cpu(); step(); end
        cpu_wr = 1'b0;
        pulse_reset();
        measure_busy("busy_after_mid_reset");

        rand_cycles(400);
        repeat (4) step();
        chk("host_acks_outstanding", 32'(hq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
